// File: rtl/resonant_sys_seq.sv
// Resonant-system emulator: a writable Q-vs-i_ref LUT, a restoring divider for
// the pulse count, and a start/busy/done pulse serialiser with abort on start low.
module resonant_sys_seq #(
   parameter int unsigned BUS_WIDTH      = 10,
   parameter int unsigned PULSE_DURATION = 3,
   parameter int unsigned Q_PER_PULSE    = 30
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 lut_we,
   input  logic [BUS_WIDTH-1:0] lut_addr,
   input  logic [BUS_WIDTH-1:0] lut_wdata,
   input  logic [BUS_WIDTH-1:0] i_ref,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic [BUS_WIDTH-1:0] n_of_pulses,
   output logic                 q_serialized
);

   localparam int unsigned W     = BUS_WIDTH;
   localparam int unsigned RW    = BUS_WIDTH + 1;
   localparam int unsigned XW    = BUS_WIDTH + 2;
   localparam int unsigned DEPTH = 2 ** BUS_WIDTH;
   localparam int unsigned PH_W  = (PULSE_DURATION > 1) ? $clog2(PULSE_DURATION) : 1;
   localparam int unsigned IT_W  = $clog2(BUS_WIDTH + 1);

   localparam logic [PH_W-1:0] PH_LAST = PH_W'(PULSE_DURATION - 1);
   localparam logic [IT_W-1:0] IT_LAST = IT_W'(BUS_WIDTH - 1);
   localparam logic [XW-1:0]   DIVISOR = XW'(Q_PER_PULSE);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOOKUP,
      S_DIVIDE,
      S_PULSE
   } state_e;

   state_e          state_q, state_d;
   logic            start_q;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            qser_q, qser_d;
   logic [W-1:0]    nout_q, nout_d;
   logic [W-1:0]    idx_q, idx_d;
   logic [W-1:0]    qreg_q, qreg_d;
   logic [RW-1:0]   rem_q, rem_d;
   logic [W-1:0]    quo_q, quo_d;
   logic [IT_W-1:0] it_q, it_d;
   logic [PH_W-1:0] ph_q, ph_d;
   logic [W-1:0]    pcnt_q, pcnt_d;

   logic [W-1:0]    lut_mem [DEPTH];

   logic            trigger_c;
   logic [XW-1:0]   rem_wide;
   logic [XW-1:0]   rem_diff;
   logic            rem_ge;
   logic [W-1:0]    quo_next;
   logic [W-1:0]    n_clamped;

   assign busy         = busy_q;
   assign done         = done_q;
   assign n_of_pulses  = nout_q;
   assign q_serialized = qser_q;

   assign trigger_c = start & ~start_q;

   // LUT storage is deliberately not reset; reads happen only in LOOKUP (read-first)
   always_ff @(posedge clk) begin
      if (lut_we) lut_mem[lut_addr] <= lut_wdata;
   end

   always_comb begin
      state_d = state_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      qser_d  = qser_q;
      nout_d  = nout_q;
      idx_d   = idx_q;
      qreg_d  = qreg_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      it_d    = it_q;
      ph_d    = ph_q;
      pcnt_d  = pcnt_q;

      // One restoring-division step: shift in the next dividend MSB, trial-subtract
      rem_wide  = {rem_q, qreg_q[W-1]};
      rem_diff  = rem_wide - DIVISOR;
      rem_ge    = (rem_wide >= DIVISOR);
      quo_next  = W'({quo_q, rem_ge});
      n_clamped = (quo_next == '0) ? W'(1) : quo_next;

      unique case (state_q)
         S_IDLE: begin
            if (trigger_c) begin
               idx_d   = i_ref;
               busy_d  = 1'b1;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (!start) begin
               busy_d  = 1'b0;
               qser_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               qreg_d  = lut_mem[idx_q];
               rem_d   = '0;
               quo_d   = '0;
               it_d    = '0;
               state_d = S_DIVIDE;
            end
         end
         S_DIVIDE: begin
            if (!start) begin
               busy_d  = 1'b0;
               qser_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               rem_d  = RW'(rem_ge ? rem_diff : rem_wide);
               qreg_d = qreg_q << 1;
               quo_d  = quo_next;
               it_d   = it_q + IT_W'(1);
               if (it_q == IT_LAST) begin
                  nout_d  = n_clamped;
                  pcnt_d  = n_clamped;
                  qser_d  = 1'b1;
                  ph_d    = '0;
                  state_d = S_PULSE;
               end
            end
         end
         S_PULSE: begin
            if (!start) begin
               busy_d  = 1'b0;
               qser_d  = 1'b0;
               state_d = S_IDLE;
            end else if (ph_q == PH_LAST) begin
               ph_d = '0;
               if (qser_q) begin
                  qser_d = 1'b0;
               end else begin
                  pcnt_d = pcnt_q - W'(1);
                  if (pcnt_q == W'(1)) begin
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     qser_d = 1'b1;
                  end
               end
            end else begin
               ph_d = ph_q + PH_W'(1);
            end
         end
         default: begin
            busy_d  = 1'b0;
            qser_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         qser_q  <= 1'b0;
         nout_q  <= '0;
         idx_q   <= '0;
         qreg_q  <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         it_q    <= '0;
         ph_q    <= '0;
         pcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         start_q <= start;
         busy_q  <= busy_d;
         done_q  <= done_d;
         qser_q  <= qser_d;
         nout_q  <= nout_d;
         idx_q   <= idx_d;
         qreg_q  <= qreg_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         it_q    <= it_d;
         ph_q    <= ph_d;
         pcnt_q  <= pcnt_d;
      end
   end

endmodule

// File: doc/resonant_sys_seq.md
# resonant_sys_seq

Clocked, synthesizable successor to the behavioural resonant-system emulator. It holds a writable Q-versus-i_ref lookup table and looks up Q for a latched i_ref. An iterative divider computes the pulse count. The block then serialises that many fixed-width pulses on q_serialized, with a start/busy/done handshake and abort on start deassertion. It sits between the control-current DAC model and the pulse-counting front end, and replaces the file-loaded, delay-timed model in synthesizable flows.

## Interface
- BUS_WIDTH, 10: width of i_ref, LUT data, Q and pulse count; LUT depth is 2**BUS_WIDTH.
- PULSE_DURATION, 3: clock cycles per pulse half-period (high phase and low phase each); must be ≥1.
- Q_PER_PULSE, 30: Q quantum per output pulse (divisor); 1 ≤ Q_PER_PULSE ≤ 2**BUS_WIDTH-1.
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- lut_we  in  1  LUT write enable.
- lut_addr  in  BUS_WIDTH  LUT write address.
- lut_wdata  in  BUS_WIDTH  LUT write data (Q value).
- i_ref  in  BUS_WIDTH  LUT read index; latched on start.
- start  in  1  rising edge launches a run; low level aborts a run.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse on normal completion.
- n_of_pulses  out  BUS_WIDTH  pulse count of latest run (clamped ≥1).
- q_serialized  out  1  serialised pulse train.

## Operation
- Reset: busy=0, done=0, n_of_pulses=0, q_serialized=0, state IDLE, start history register=0. LUT contents are not reset; the bench loads the LUT before use.
- LUT: synchronous write when lut_we=1, accepted in any state. Read-first: a write and a read to the same address on the same edge returns the old data.
- start history register: start_q <= start every cycle. Trigger = start & ~start_q.
- FSM states:
  - IDLE: on trigger, latch i_ref, set busy=1, and go to LOOKUP.
  - LOOKUP (1 cycle): q_reg <= LUT[latched i_ref], then go to DIVIDE.
  - DIVIDE (BUS_WIDTH cycles): restoring division q_reg / Q_PER_PULSE, one quotient bit per cycle, MSB first. The remainder register is BUS_WIDTH+1 bits. On the final iteration:
    - n_of_pulses <= (quotient==0 ? 1 : quotient)
    - pulse counter <= that same value
    - q_serialized <= 1
    - go to PULSE.
  - PULSE: phase counter runs 0..PULSE_DURATION-1.
    - High phase ends: q_serialized <= 0.
    - Low phase ends: decrement the pulse counter. If the counter was 1, go to IDLE with busy <= 0 and done <= 1; otherwise q_serialized <= 1.
- done is high for exactly one cycle.
- Abort: start=0 in LOOKUP, DIVIDE or PULSE. Next edge: q_serialized=0, busy=0, state IDLE, done stays 0, n_of_pulses unchanged.
- i_ref changes while busy are ignored. LUT writes during a run do not affect that run once LOOKUP has passed.
- start held high after done does not retrigger. A new run needs start low for at least one sampled cycle, then high again.
- A trigger in the same cycle as done cannot occur, because start must be high to reach done.

## Timing
- Edge 0 is the edge at which the trigger is sampled. busy=1 from edge 0.
- q_serialized first rises at edge BUS_WIDTH+1.
- Pulse k (k=0..n-1):
  - rises at edge BUS_WIDTH+1+2·k·PULSE_DURATION;
  - falls PULSE_DURATION edges later.
- done=1 and busy=0 at edge BUS_WIDTH+1+2·n·PULSE_DURATION. done clears on the next edge.
- n_of_pulses updates at edge BUS_WIDTH+1.
- Reset assertion mid-run forces all outputs to their reset values immediately, without waiting for a clock edge. Release is synchronised by the bench to avoid edges coincident with rst_n rising.

## Test plan
- Defaults apply. LUT[5]=95; start rises with i_ref=5 → n_of_pulses=3 at edge 11; three pulses, each 3 cycles high and 3 low; done at edge 29.
- LUT[0]=10, i_ref=0 → quotient 0 clamped; n_of_pulses=1, one pulse, done at edge 17.
- LUT[1023]=1023, i_ref=1023 → n_of_pulses=34, 34 pulses, done at edge 215; no address wrap.
- Abort during PULSE (LUT[5]=95): start dropped during the second high phase → q_serialized=0 and busy=0 one edge later; done never asserts; n_of_pulses stays 3.
- Reset during DIVIDE: rst_n low → busy, done and q_serialized are 0 with no clock edge. After release, a fresh start rise with LUT[5]=95 runs normally (n=3).
- Robustness run (LUT[5]=95):
  - i_ref toggled to 7 during DIVIDE → no effect;
  - lut_we writes LUT[5]=300 during PULSE → n stays 3;
  - start held high after done → no second run;
  - start low 1 cycle then high → new run with n=10.
